edge_flit_tx: RTL and testbench

EDGE_FLIT_TX -- requirements
Module: edge_flit_tx

---
 rtl/edge_flit_tx_if.sv | 23 ++
 rtl/edge_flit_tx.sv | 114 +++++++++++
 tb/tb_edge_flit_tx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_flit_tx_if.sv
// rtl/edge_flit_tx_if.sv - host-side packet handshake bundle for edge_flit_tx
interface edge_flit_tx_if #(
  parameter int PAY_FLITS = 2
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [3:0]             pkt_dest;
  logic [4*PAY_FLITS-1:0] pkt_payload;

  modport master (
    output pkt_valid,
    output pkt_dest,
    output pkt_payload,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_dest,
    input  pkt_payload,
    output pkt_ready
  );
endinterface

// File: rtl/edge_flit_tx.sv
// rtl/edge_flit_tx.sv - packet FIFO feeding a cell edge port as head + payload flits
module edge_flit_tx #(
  parameter int DEPTH     = 4,
  parameter int PAY_FLITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  edge_flit_tx_if.slave pkt,
  output logic [3:0]    flit_out,
  output logic          flit_en,
  input  logic          cell_full,
  output logic          busy,
  output logic [4:0]    fifo_count,
  output logic [15:0]   sent_count
);
  localparam int PB = 4 * PAY_FLITS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      mem_dest [DEPTH];
  logic [PB-1:0]   mem_pay  [DEPTH];
  logic [3:0]      head_q;
  logic [PB-1:0]   shift_q;
  logic [1:0]      idx_q, idx_d;
  logic            push, pop, send, last_flit, fifo_nonempty;

  assign fifo_nonempty = (fifo_count != 5'd0);
  assign pkt.pkt_ready = (fifo_count < 5'(DEPTH));
  assign push          = pkt.pkt_valid && pkt.pkt_ready;
  assign busy          = (state_q != IDLE) || fifo_nonempty;
  assign last_flit     = (idx_q == 2'(PAY_FLITS - 1));

  // cell_full freezes every state, IDLE included, so a stalled edge leaves packets in the FIFO
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    send     = 1'b0;
    flit_out = 4'h0;
    flit_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty && !cell_full) begin
          state_d = HEAD;
          pop     = 1'b1;
        end
      end
      HEAD: begin
        flit_out = head_q;
        flit_en  = !cell_full;
        send     = !cell_full;
        if (send) begin
          state_d = BODY;
          idx_d   = 2'd0;
        end
      end
      BODY: begin
        flit_out = shift_q[PB-1 -: 4];
        flit_en  = !cell_full;
        send     = !cell_full;
        if (send) begin
          if (last_flit) begin
            if (fifo_nonempty) begin
              state_d = HEAD;
              pop     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
      sent_count <= 16'd0;
      head_q     <= 4'h0;
      shift_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        head_q  <= mem_dest[rd_ptr];
        shift_q <= mem_pay[rd_ptr];
      end else if (send && state_q == BODY) begin
        shift_q <= shift_q << 4;
      end
      fifo_count <= fifo_count + 5'(push) - 5'(pop);
      if (send && state_q == BODY && last_flit) sent_count <= sent_count + 16'd1;
    end
  end

  // storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest[wr_ptr] <= pkt.pkt_dest;
      mem_pay[wr_ptr]  <= pkt.pkt_payload;
    end
  end
endmodule

// File: tb/tb_edge_flit_tx.sv
// tb/tb_edge_flit_tx.sv - randomized self-checking bench for edge_flit_tx
module tb_edge_flit_tx;
  localparam int DEPTH     = 4;
  localparam int PAY_FLITS = 2;
  localparam int PB        = 4 * PAY_FLITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cell_full = 1'b0;
  logic [3:0]  flit_out;
  logic        flit_en;
  logic        busy;
  logic [4:0]  fifo_count;
  logic [15:0] sent_count;

  edge_flit_tx_if #(.PAY_FLITS(PAY_FLITS)) pkt_if ();

  edge_flit_tx #(.DEPTH(DEPTH), .PAY_FLITS(PAY_FLITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt        (pkt_if),
    .flit_out   (flit_out),
    .flit_en    (flit_en),
    .cell_full  (cell_full),
    .busy       (busy),
    .fifo_count (fifo_count),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  got_q[$];
  int          got_cyc[$];
  logic [3:0]  exp_q[$];
  logic [15:0] exp_sent = 16'd0;

  always @(posedge clk) cyc++;

  // cell-side receiver: a flit is taken on the rising edge that follows a high flit_en
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (flit_en === 1'b1 && cell_full === 1'b1) begin
        errors++;
        $display("FAIL en_vs_full: flit_en=%b cell_full=%b required not both high", flit_en, cell_full);
      end
      if (flit_en === 1'b1) begin
        got_q.push_back(flit_out);
        got_cyc.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_streams();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic offer(input logic [3:0] d, input logic [PB-1:0] p, output bit acc);
    pkt_if.pkt_valid   = 1'b1;
    pkt_if.pkt_dest    = d;
    pkt_if.pkt_payload = p;
    acc = pkt_if.pkt_ready;
    tick();
    pkt_if.pkt_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(d);
      for (int k = PAY_FLITS - 1; k >= 0; k--) exp_q.push_back(p[k*4 +: 4]);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks += 6;
    if (flit_out !== 4'h0)    begin errors++; $display("FAIL rst_flit_out: got %h required 0", flit_out); end
    if (flit_en !== 1'b0)     begin errors++; $display("FAIL rst_flit_en: got %b required 0", flit_en); end
    if (pkt_if.pkt_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", pkt_if.pkt_ready); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (fifo_count !== 5'd0)  begin errors++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
    if (sent_count !== 16'd0) begin errors++; $display("FAIL rst_sent: got %0d required 0", sent_count); end
    rst_n = 1'b1;
    exp_sent = 16'd0;
  endtask

  task automatic test_single();
    bit acc;
    int acc_cyc;
    clear_streams();
    offer(4'hA, 8'h3C, acc);
    acc_cyc = cyc;
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: ready %b required 1", acc); end
    wait_idle(20, "single");
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL single_len: got %0d flits required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks += 2;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      end
      if (i >= got_cyc.size() || got_cyc[i] != acc_cyc + 2 + i) begin
        errors++;
        $display("FAIL single_time%0d: got edge %0d required %0d", i, (i < got_cyc.size()) ? got_cyc[i] : -1, acc_cyc + 2 + i);
      end
    end
    exp_sent++;
    checks++;
    if (sent_count !== exp_sent) begin errors++; $display("FAIL single_sent: got %0d required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int acc_cyc;
    int want[3];
    clear_streams();
    offer(4'h6, 8'h3C, acc);
    acc_cyc = cyc;
    tick();
    tick();
    cell_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 2;
      if (flit_en !== 1'b0)  begin errors++; $display("FAIL bp_en%0d: got %b required 0", i, flit_en); end
      if (flit_out !== 4'h3) begin errors++; $display("FAIL bp_out%0d: got %h required 3", i, flit_out); end
      @(posedge clk);
    end
    #1;
    cell_full = 1'b0;
    wait_idle(20, "bp");
    want = '{acc_cyc + 2, acc_cyc + 6, acc_cyc + 7};
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL bp_len: got %0d flits required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks += 2;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      end
      if (i >= got_cyc.size() || got_cyc[i] != want[i]) begin
        errors++;
        $display("FAIL bp_time%0d: got edge %0d required %0d", i, (i < got_cyc.size()) ? got_cyc[i] : -1, want[i]);
      end
    end
    exp_sent++;
    checks++;
    if (sent_count !== exp_sent) begin errors++; $display("FAIL bp_sent: got %0d required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_fifo_full();
    bit rdy[5];
    clear_streams();
    cell_full = 1'b1;
    for (int i = 0; i < 5; i++) offer(4'(i + 1), 8'($urandom), rdy[i]);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdy[i] !== (i < DEPTH)) begin errors++; $display("FAIL full_ready%0d: got %b required %b", i, rdy[i], i < DEPTH); end
    end
    checks += 3;
    if (fifo_count !== 5'd4) begin errors++; $display("FAIL full_count: got %0d required 4", fifo_count); end
    if (pkt_if.pkt_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", pkt_if.pkt_ready); end
    if (got_q.size() != 0) begin errors++; $display("FAIL full_stalled: got %0d flits required 0", got_q.size()); end
    cell_full = 1'b0;
    wait_idle(40, "full");
    checks++;
    if (got_q.size() != 12) begin errors++; $display("FAIL full_len: got %0d flits required 12", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin errors++; $display("FAIL full_gap%0d: got edge %0d required %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    exp_sent += 16'd4;
    checks++;
    if (sent_count !== exp_sent) begin errors++; $display("FAIL full_sent: got %0d required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_wrap();
    bit acc;
    int acc_n = 0;
    int n = 0;
    clear_streams();
    while ((acc_n < 20 || busy !== 1'b0) && n < 3000) begin
      cell_full = 1'($urandom % 2);
      if (acc_n < 20 && ($urandom % 4) != 0) begin
        offer(4'($urandom), 8'($urandom), acc);
        if (acc) acc_n++;
      end else begin
        tick();
      end
      n++;
    end
    cell_full = 1'b0;
    checks += 2;
    if (n >= 3000) begin errors++; $display("FAIL wrap_timeout: accepted %0d busy %b required 20 and 0", acc_n, busy); end
    if (got_q.size() != 20 * (1 + PAY_FLITS)) begin errors++; $display("FAIL wrap_len: got %0d flits required %0d", got_q.size(), 20 * (1 + PAY_FLITS)); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      end
    end
    exp_sent += 16'd20;
    checks++;
    if (sent_count !== exp_sent) begin errors++; $display("FAIL wrap_sent: got %0d required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    clear_streams();
    offer(4'h9, 8'h5A, acc);
    offer(4'h4, 8'hB1, acc);
    tick();
    rst_n = 1'b0;
    #1;
    exp_sent = 16'd0;
    checks += 5;
    if (flit_en !== 1'b0)     begin errors++; $display("FAIL mid_en: got %b required 0", flit_en); end
    if (flit_out !== 4'h0)    begin errors++; $display("FAIL mid_out: got %h required 0", flit_out); end
    if (fifo_count !== 5'd0)  begin errors++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
    if (sent_count !== exp_sent) begin errors++; $display("FAIL mid_sent: got %0d required 0", sent_count); end
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 4'h9) begin errors++; $display("FAIL mid_head: got %0d flits required only head 9", got_q.size()); end
    clear_streams();
    offer(4'h2, 8'hE7, acc);
    checks += 2;
    if (acc !== 1'b1) begin errors++; $display("FAIL mid_accept: ready %b required 1", acc); end
    if (fifo_count !== 5'd1) begin errors++; $display("FAIL mid_first_accept: count %0d required 1", fifo_count); end
    wait_idle(20, "mid");
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL mid_len: got %0d flits required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_flit%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      end
    end
    exp_sent++;
    checks++;
    if (sent_count !== exp_sent) begin errors++; $display("FAIL mid_sent_after: got %0d required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_counter_wrap();
    bit acc;
    clear_streams();
    force dut.sent_count = 16'hFFFF;
    tick();
    release dut.sent_count;
    offer(4'h1, 8'h77, acc);
    wait_idle(20, "cwrap");
    checks++;
    if (sent_count !== 16'h0000) begin errors++; $display("FAIL cwrap_sent: got %h required 0000", sent_count); end
  endtask

  initial begin
    pkt_if.pkt_valid   = 1'b0;
    pkt_if.pkt_dest    = 4'h0;
    pkt_if.pkt_payload = '0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_fifo_full();
    test_wrap();
    test_reset_mid();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
